// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 5-8 data bits, none/even/odd parity, 1/1.5/2 stop bits.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    input  logic [2:0] dbit_select_i,
    input  logic [1:0] sbit_select_i,
    input  logic [1:0] parity_select_i,
    output logic [7:0] rx_dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] HALF  = 5'(OVERSAMPLE / 2 - 1);
    localparam logic [4:0] LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0] LAST3 = 5'(OVERSAMPLE * 3 / 2 - 1);
    localparam logic [4:0] LAST4 = 5'(OVERSAMPLE * 2 - 1);

    state_t     r_state, w_next;
    logic       r_rx_m, r_rx_s;
    logic [4:0] r_tick;
    logic [2:0] r_bit;
    logic [7:0] r_sh;
    logic [3:0] r_nb;
    logic [1:0] r_sbit, r_par;
    logic       r_px, r_perr, r_ferr, r_armed;
    logic       w_tick_last, w_stop_low, w_clr;
    logic [4:0] w_stop_last;

    assign w_tick_last = s_tick && r_tick == LAST;
    assign w_stop_last = r_sbit == 2'b01 ? LAST3 : r_sbit == 2'b10 ? LAST4 : LAST;
    // stop samples land mid-bit: tick 15, plus tick 31 for two stop bits
    assign w_stop_low  = s_tick && !r_rx_s && (r_tick == LAST || (r_tick == LAST4 && r_sbit == 2'b10));
    assign w_clr       = r_state == IDLE || w_next != r_state || (r_state == DATA && w_tick_last);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (r_armed && !r_rx_s) w_next = START;
            START:   if (s_tick && r_tick == HALF) w_next = r_rx_s ? IDLE : DATA;
            DATA:    if (w_tick_last && r_bit == 3'(r_nb - 4'd1)) w_next = ^r_par ? PARITY : STOP;
            PARITY:  if (w_tick_last) w_next = STOP;
            STOP:    if (s_tick && r_tick == w_stop_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_rx_m       <= 1'b1;
            r_rx_s       <= 1'b1;
            r_tick       <= 5'd0;
            r_bit        <= 3'd0;
            r_sh         <= 8'd0;
            r_nb         <= 4'd8;
            r_sbit       <= 2'b00;
            r_par        <= 2'b00;
            r_px         <= 1'b0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_armed      <= 1'b1;
            rx_dout      <= 8'd0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_rx_m       <= rx;
            r_rx_s       <= r_rx_m;
            r_state      <= w_next;
            rx_done_tick <= 1'b0;
            r_tick       <= w_clr ? 5'd0 : r_tick + {4'd0, s_tick};
            // config is tracked while idle so the value held is the one present at start detection
            if (r_state == IDLE) begin
                r_armed <= r_armed | r_rx_s;
                r_nb    <= dbit_select_i[2] ? 4'd8 : 4'd5 + {2'b00, dbit_select_i[1:0]};
                r_sbit  <= sbit_select_i;
                r_par   <= parity_select_i;
                r_bit   <= 3'd0;
                r_px    <= 1'b0;
                r_perr  <= 1'b0;
                r_ferr  <= 1'b0;
            end
            if (r_state == DATA && w_tick_last) begin
                r_sh  <= {r_rx_s, r_sh[7:1]};
                r_px  <= r_px ^ r_rx_s;
                r_bit <= r_bit + 3'd1;
            end
            if (r_state == PARITY && w_tick_last) r_perr <= r_px ^ r_rx_s ^ (r_par == 2'b10);
            if (r_state == STOP && w_stop_low) r_ferr <= 1'b1;
            if (r_state == STOP && w_next == IDLE) begin
                rx_done_tick <= 1'b1;
                rx_dout      <= r_sh >> (4'd8 - r_nb);
                parity_err   <= r_perr;
                frame_err    <= r_ferr | w_stop_low;
                r_armed      <= !(r_ferr | w_stop_low);
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames on the serial line with hand-computed expected words and flags.
module tb_uart_rx;
    localparam int DIV  = 4;
    localparam int BITC = 16 * DIV;

    logic       clk = 1'b0, reset = 1'b1, rx = 1'b1;
    logic [1:0] r_div = 2'd0;
    logic       s_tick;
    logic [2:0] dbit = 3'b011;
    logic [1:0] sbit = 2'b00, par = 2'b00;
    logic [7:0] rx_dout;
    logic       rx_done_tick, parity_err, frame_err;
    logic [7:0] v;
    int cyc = 0, done_cnt = 0, done_cyc = 0, t0 = 0;
    int passed = 0, total = 0, fails = 0, c = 0, lat1 = 0;

    uart_rx dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .dbit_select_i(dbit), .sbit_select_i(sbit), .parity_select_i(par),
        .rx_dout(rx_dout), .rx_done_tick(rx_done_tick),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        r_div <= r_div + 2'd1;
        cyc   <= cyc + 1;
    end
    assign s_tick = r_div == 2'd3;
    always @(negedge clk) if (rx_done_tick) begin
        done_cnt++;
        done_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int nb, input int pm, input int hs, input bit flip, input bit sv);
        logic p;
        @(posedge clk);
        while (r_div != 2'd0) @(posedge clk);
        #1 t0 = cyc;
        rx = 1'b0;
        repeat (BITC) @(posedge clk);
        p = (pm == 2);
        for (int i = 0; i < nb; i++) begin
            #1 rx = d[i];
            p ^= d[i];
            repeat (BITC) @(posedge clk);
        end
        if (pm != 0) begin
            #1 rx = p ^ flip;
            repeat (BITC) @(posedge clk);
        end
        #1 rx = sv;
        repeat (hs * BITC / 2) @(posedge clk);
        #1;
    endtask

    initial begin
        idle(4);
        reset = 1'b0;
        idle(2);
        check("rst_dout", rx_dout, 0);
        check("rst_done", rx_done_tick, 0);
        check("rst_perr", parity_err, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_cnt", done_cnt, 0);

        c = done_cnt;
        send(8'hAC, 8, 0, 2, 0, 1);
        idle(20);
        check("8n1_cnt", done_cnt, c + 1);
        check("8n1_dout", rx_dout, 8'hAC);
        check("8n1_perr", parity_err, 0);
        check("8n1_ferr", frame_err, 0);

        dbit = 3'b010; par = 2'b01; sbit = 2'b00;
        send(8'h55, 7, 1, 2, 0, 1);
        lat1 = done_cyc - t0;
        check("7e1_dout", rx_dout, 8'h55);
        idle(20);
        sbit = 2'b10;
        send(8'h55, 7, 1, 4, 0, 1);
        check("7e2_dout", rx_dout, 8'h55);
        check("7e2_perr", parity_err, 0);
        check("7e2_ferr", frame_err, 0);
        check("7e2_extra_lat", done_cyc - t0 - lat1, BITC);

        dbit = 3'b011; par = 2'b10; sbit = 2'b01;
        c = done_cnt;
        send(8'hF0, 8, 2, 3, 0, 1);
        idle(20);
        check("8o15_dout", rx_dout, 8'hF0);
        check("8o15_perr", parity_err, 0);
        check("8o15_ferr", frame_err, 0);

        dbit = 3'b000; par = 2'b00; sbit = 2'b00;
        send(8'h15, 5, 0, 2, 0, 1);
        check("5n1_dout", rx_dout, 8'h15);

        dbit = 3'b011;
        send(8'hAA, 8, 0, 2, 0, 1);
        check("b2b_aa", rx_dout, 8'hAA);
        send(8'h55, 8, 0, 2, 0, 1);
        check("b2b_55", rx_dout, 8'h55);
        check("seq_cnt", done_cnt, c + 4);
        check("seq_errs", {parity_err, frame_err}, 0);

        par = 2'b01;
        send(8'h03, 8, 1, 2, 1, 1);
        check("perr_dout", rx_dout, 8'h03);
        check("perr_flag", parity_err, 1);
        check("perr_ferr", frame_err, 0);
        send(8'h07, 8, 1, 2, 0, 1);
        check("perr_clr_dout", rx_dout, 8'h07);
        check("perr_clr", parity_err, 0);

        par = 2'b00;
        c = done_cnt;
        send(8'h81, 8, 0, 2, 0, 0);
        idle(2000);
        check("ferr_cnt", done_cnt, c + 1);
        check("ferr_dout", rx_dout, 8'h81);
        check("ferr_flag", frame_err, 1);

        rx = 1'b1;
        idle(100);
        c = done_cnt;
        v = 8'h5A;
        @(posedge clk);
        while (r_div != 2'd0) @(posedge clk);
        #1 rx = 1'b0;
        repeat (BITC) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 rx = v[i];
            repeat (BITC) @(posedge clk);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rx = 1'b1;
        idle(1000);
        check("rstmid_cnt", done_cnt, c);
        check("rstmid_dout", rx_dout, 0);
        check("rstmid_perr", parity_err, 0);
        check("rstmid_ferr", frame_err, 0);
        send(8'h3C, 8, 0, 2, 0, 1);
        idle(20);
        check("post_rst_cnt", done_cnt, c + 1);
        check("post_rst_dout", rx_dout, 8'h3C);

        c = done_cnt;
        rx = 1'b0;
        idle(4 * DIV);
        rx = 1'b1;
        idle(300);
        check("glitch_cnt", done_cnt, c);
        send(8'hC3, 8, 0, 2, 0, 1);
        check("glitch_next", rx_dout, 8'hC3);

        c = done_cnt;
        rx = 1'b0;
        idle(3000);
        check("break_cnt", done_cnt, c + 1);
        check("break_dout", rx_dout, 0);
        check("break_ferr", frame_err, 1);
        rx = 1'b1;
        idle(100);
        send(8'h99, 8, 0, 2, 0, 1);
        check("break_rec_dout", rx_dout, 8'h99);
        check("break_rec_ferr", frame_err, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
